// File: rtl/memory_port_arbiter.sv
// Shares the single core memory port between instruction fetch (I) and the data path (D).
// One pending entry per requester, D-first arbitration with an anti-starvation override, flush-aware fetch drop.
module memory_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic        d_fence,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        m_valid,
  output logic        m_instr,
  output logic        m_fence,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready,
  input  logic [31:0] m_rdata
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] BUSY_I    = 2'd1;
  localparam logic [1:0] BUSY_D    = 2'd2;
  localparam logic [1:0] BUSY_DROP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              run_q;
  logic              i_pend_q;
  logic [ADDR_W-1:0] i_addr_q;
  logic              d_pend_q;
  logic              d_fence_q;
  logic [ADDR_W-1:0] d_addr_q;
  logic [DATA_W-1:0] d_wdata_q;
  logic [STRB_W-1:0] d_wstrb_q;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic i_avail, d_avail, done, can_issue, grant_i, grant_d;

  // Arbitration: the port is free in IDLE or in the cycle the current access completes.
  always_comb begin
    i_avail   = ~i_flush & (i_valid | i_pend_q);
    d_avail   = d_valid | d_pend_q;
    done      = m_ready & (state_q != IDLE);
    can_issue = run_q & ((state_q == IDLE) | done);
    grant_i   = can_issue & i_avail & (~d_avail | (starve_q == STARVE_MAX));
    grant_d   = can_issue & d_avail & ~grant_i;
  end

  // Starve counter: counts D wins over a waiting fetch, cleared once fetch is served or gone.
  always_comb begin
    starve_d = starve_q;
    if (!i_avail || grant_i) begin
      starve_d = '0;
    end else if (grant_d && (starve_q < STARVE_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Next state and port/response outputs.
  always_comb begin
    state_d = state_q;
    i_ready = 1'b0;
    i_rdata = '0;
    d_ready = 1'b0;
    d_rdata = '0;
    m_valid = 1'b0;
    m_instr = 1'b0;
    m_fence = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;

    case (state_q)
      BUSY_I: begin
        if (m_ready) begin
          state_d = IDLE;
          if (!i_flush) begin
            i_ready = 1'b1;
            i_rdata = m_rdata;
          end
        end else if (i_flush) begin
          state_d = BUSY_DROP;
        end
      end
      BUSY_D: begin
        if (m_ready) begin
          state_d = IDLE;
          d_ready = 1'b1;
          d_rdata = m_rdata;
        end
      end
      BUSY_DROP: begin
        if (m_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_i) begin
      state_d = BUSY_I;
      m_valid = 1'b1;
      m_instr = 1'b1;
      m_addr  = i_valid ? i_addr : i_addr_q;
    end else if (grant_d) begin
      state_d = BUSY_D;
      m_valid = 1'b1;
      m_fence = d_valid ? d_fence : d_fence_q;
      m_addr  = d_valid ? d_addr  : d_addr_q;
      m_wdata = d_valid ? d_wdata : d_wdata_q;
      m_wstrb = d_valid ? d_wstrb : d_wstrb_q;
    end
  end

  // run_q holds every output quiet until the first clock after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      starve_q <= starve_d;
    end
  end

  // Pending entries: a granted or flushed entry is cleared, a new pulse overwrites.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_pend_q  <= 1'b0;
      i_addr_q  <= '0;
      d_pend_q  <= 1'b0;
      d_fence_q <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_wstrb_q <= '0;
    end else begin
      if (i_flush || grant_i) begin
        i_pend_q <= 1'b0;
      end else if (i_valid) begin
        i_pend_q <= 1'b1;
        i_addr_q <= i_addr;
      end
      if (grant_d) begin
        d_pend_q <= 1'b0;
      end else if (d_valid) begin
        d_pend_q  <= 1'b1;
        d_fence_q <= d_fence;
        d_addr_q  <= d_addr;
        d_wdata_q <= d_wdata;
        d_wstrb_q <= d_wstrb;
      end
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: expected port requests and responses are queued
// as stimulus is driven and checked by a negedge monitor.
module tb_memory_port_arbiter;

  logic        clock;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_flush;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_valid;
  logic        d_fence;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        m_valid;
  logic        m_instr;
  logic        m_fence;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;

  typedef struct packed {
    logic        instr;
    logic        fence;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  req_t        mon_r;
  int          n_tests = 0;
  int          n_fail  = 0;

  memory_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .i_valid (i_valid),
    .i_addr  (i_addr),
    .i_flush (i_flush),
    .i_ready (i_ready),
    .i_rdata (i_rdata),
    .d_valid (d_valid),
    .d_fence (d_fence),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_wstrb (d_wstrb),
    .d_ready (d_ready),
    .d_rdata (d_rdata),
    .m_valid (m_valid),
    .m_instr (m_instr),
    .m_fence (m_fence),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_ready (m_ready),
    .m_rdata (m_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    i_valid = 1'b0; i_addr = '0; i_flush = 1'b0;
    d_valid = 1'b0; d_fence = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    m_ready = 1'b0; m_rdata = '0;
  endtask

  task automatic push_req(input logic instr, input logic fence, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    req_t r;
    r.instr = instr; r.fence = fence; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
    exp_req.push_back(r);
  endtask

  // Expected request must already have been issued within the cycle just ended.
  task automatic check_drained(input string tag);
    check(tag, 32'(exp_req.size()), 32'd0);
  endtask

  // Monitor: every port request and every ready must match the head of its queue.
  always @(negedge clock) begin
    if (reset) begin
      if (m_valid) begin
        if (exp_req.size() == 0) begin
          check("m_valid_unexpected", 32'(m_valid), 32'd0);
        end else begin
          mon_r = exp_req.pop_front();
          check("m_instr", 32'(m_instr), 32'(mon_r.instr));
          check("m_fence", 32'(m_fence), 32'(mon_r.fence));
          check("m_addr",  m_addr,       mon_r.addr);
          check("m_wdata", m_wdata,      mon_r.wdata);
          check("m_wstrb", 32'(m_wstrb), 32'(mon_r.wstrb));
        end
      end
      if (i_ready) begin
        if (exp_i.size() == 0) check("i_ready_unexpected", 32'(i_ready), 32'd0);
        else check("i_rdata", i_rdata, exp_i.pop_front());
      end else begin
        check("i_rdata_quiet", i_rdata, 32'd0);
      end
      if (d_ready) begin
        if (exp_d.size() == 0) check("d_ready_unexpected", 32'(d_ready), 32'd0);
        else check("d_rdata", d_rdata, exp_d.pop_front());
      end else begin
        check("d_rdata_quiet", d_rdata, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b0;
    idle_in();
    repeat (2) tick();

    // Reset state: outputs quiet even with a request presented.
    i_valid = 1'b1; i_addr = 32'h55; d_valid = 1'b1; d_addr = 32'h66;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_addr",  m_addr,       32'd0);
    check("rst_i_ready", 32'(i_ready), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    tick();
    idle_in();
    reset = 1'b1;
    repeat (2) tick();

    // m_ready while idle is ignored.
    m_ready = 1'b1; m_rdata = 32'h99;
    tick(); idle_in();

    // Lone fetch.
    push_req(1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    i_valid = 1'b1; i_addr = 32'h80;
    tick(); idle_in();
    check_drained("fetch_issue");
    tick();
    exp_i.push_back(32'hA5A5_A5A5);
    m_ready = 1'b1; m_rdata = 32'hA5A5_A5A5;
    tick(); idle_in();

    // Collision: D first, then pending I back-to-back on D's completion.
    push_req(1'b0, 1'b0, 32'h8000, 32'h0, 4'h0);
    i_valid = 1'b1; i_addr = 32'h100; d_valid = 1'b1; d_addr = 32'h8000;
    tick(); idle_in();
    check_drained("collision_d_first");
    push_req(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    exp_d.push_back(32'h1111);
    m_ready = 1'b1; m_rdata = 32'h1111;
    tick(); idle_in();
    check_drained("b2b_i_issue");
    exp_i.push_back(32'h2222);
    m_ready = 1'b1; m_rdata = 32'h2222;
    tick(); idle_in();

    // Store and fence.
    push_req(1'b0, 1'b0, 32'h40, 32'h1234, 4'b0011);
    d_valid = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234; d_wstrb = 4'b0011;
    tick(); idle_in();
    tick();
    exp_d.push_back(32'h0);
    m_ready = 1'b1;
    tick(); idle_in();
    push_req(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    d_valid = 1'b1; d_fence = 1'b1;
    tick(); idle_in();
    exp_d.push_back(32'hF00D);
    m_ready = 1'b1; m_rdata = 32'hF00D;
    tick(); idle_in();

    // Flush while fetch in flight: response dropped, arbiter back in IDLE.
    push_req(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    i_valid = 1'b1; i_addr = 32'h200;
    tick(); idle_in();
    i_flush = 1'b1;
    tick(); idle_in();
    m_ready = 1'b1; m_rdata = 32'hDEAD_BEEF;
    tick(); idle_in();
    push_req(1'b0, 1'b0, 32'h3000, 32'h0, 4'h0);
    d_valid = 1'b1; d_addr = 32'h3000;
    tick(); idle_in();
    check_drained("idle_after_drop");
    exp_d.push_back(32'h33);
    m_ready = 1'b1; m_rdata = 32'h33;
    tick(); idle_in();

    // Flush coincident with m_ready in BUSY_I.
    push_req(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    i_valid = 1'b1; i_addr = 32'h300;
    tick(); idle_in();
    m_ready = 1'b1; i_flush = 1'b1; m_rdata = 32'h44;
    tick(); idle_in();

    // Flush kills a pending fetch; fetch pulse with flush is ignored.
    push_req(1'b0, 1'b0, 32'h5000, 32'h0, 4'h0);
    d_valid = 1'b1; d_addr = 32'h5000; i_valid = 1'b1; i_addr = 32'h600;
    tick(); idle_in();
    i_flush = 1'b1;
    tick(); idle_in();
    exp_d.push_back(32'h55);
    m_ready = 1'b1; m_rdata = 32'h55;
    tick(); idle_in();
    i_valid = 1'b1; i_flush = 1'b1; i_addr = 32'h700;
    tick(); idle_in();
    repeat (2) tick();

    // Starvation: four D grants over a waiting fetch, then the fetch wins.
    push_req(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0);
    i_valid = 1'b1; i_addr = 32'h400; d_valid = 1'b1; d_addr = 32'h1000;
    tick(); idle_in();
    for (int k = 1; k <= 3; k++) begin
      push_req(1'b0, 1'b0, 32'h1000 + 32'(4 * k), 32'h0, 4'h0);
      exp_d.push_back(32'(k));
      m_ready = 1'b1; m_rdata = 32'(k);
      d_valid = 1'b1; d_addr = 32'h1000 + 32'(4 * k);
      tick(); idle_in();
      check_drained($sformatf("starve_d%0d", k + 1));
    end
    push_req(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    exp_d.push_back(32'd4);
    m_ready = 1'b1; m_rdata = 32'd4; d_valid = 1'b1; d_addr = 32'h1010;
    tick(); idle_in();
    check_drained("starve_i_wins");
    push_req(1'b0, 1'b0, 32'h1010, 32'h0, 4'h0);
    exp_i.push_back(32'hC0DE);
    m_ready = 1'b1; m_rdata = 32'hC0DE;
    tick(); idle_in();
    check_drained("starve_d5_after_i");
    exp_d.push_back(32'd5);
    m_ready = 1'b1; m_rdata = 32'd5;
    tick(); idle_in();

    // Reset in the middle of BUSY_D; a late m_ready must produce nothing.
    push_req(1'b0, 1'b0, 32'h2000, 32'h0, 4'h0);
    d_valid = 1'b1; d_addr = 32'h2000;
    tick(); idle_in();
    tick();
    reset = 1'b0; i_valid = 1'b1; i_addr = 32'h123; m_ready = 1'b1; m_rdata = 32'h77;
    #1;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_d_ready", 32'(d_ready), 32'd0);
    check("midrst_d_rdata", d_rdata,      32'd0);
    check("midrst_m_addr",  m_addr,       32'd0);
    tick(); idle_in();
    reset = 1'b1;
    tick();
    m_ready = 1'b1; m_rdata = 32'h88;
    tick(); idle_in();
    push_req(1'b1, 1'b0, 32'h900, 32'h0, 4'h0);
    i_valid = 1'b1; i_addr = 32'h900;
    tick(); idle_in();
    exp_i.push_back(32'h99);
    m_ready = 1'b1; m_rdata = 32'h99;
    tick(); idle_in();
    repeat (2) tick();

    check("req_queue_empty", 32'(exp_req.size()), 32'd0);
    check("i_queue_empty",   32'(exp_i.size()),   32'd0);
    check("d_queue_empty",   32'(exp_d.size()),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
